uart_loopback64: RTL and testbench



---
 rtl/uart_loopback64_pkg.sv | 36 +++
 rtl/uart_loopback64_if.sv | 29 ++
 rtl/uart_rx8.sv | 113 +++++++++++
 rtl/uart_loopback64.sv | 193 +++++++++++++++++++
 tb/tb_uart_loopback64.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_loopback64_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loopback64_pkg
//  Description : Shared constants and FSM state encodings for the 64-bit
//                UART word serializer/deserializer.
//  Options     : RX_FRAME_TIMEOUT_EN (used by uart_loopback64)
//  Revision    : 1.0  initial release
// ============================================================================
package uart_loopback64_pkg;

    localparam int BYTES_PER_WORD = 8;
    localparam int BITS_PER_BYTE  = 8;
    localparam int TIMEOUT_MULT   = 20;

    typedef logic [1:0] tx_state_t;
    typedef logic [1:0] rx_state_t;

    // Transmit FSM state encodings
    localparam tx_state_t TX_IDLE  = 2'd0;
    localparam tx_state_t TX_START = 2'd1;
    localparam tx_state_t TX_DATA  = 2'd2;
    localparam tx_state_t TX_STOP  = 2'd3;

    // Receive FSM state encodings
    localparam rx_state_t RX_IDLE  = 2'd0;
    localparam rx_state_t RX_START = 2'd1;
    localparam rx_state_t RX_DATA  = 2'd2;
    localparam rx_state_t RX_STOP  = 2'd3;

    // Bits needed for a counter that must reach max_val
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_loopback64_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loopback64_if
//  Description : Word and serial-line signals of uart_loopback64. The slave
//                modport is the design view, master the driver view.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_loopback64_if;
    import uart_loopback64_pkg::*;

    logic [BYTES_PER_WORD*BITS_PER_BYTE-1:0] data_in_64;
    logic                                    manual_start;
    logic                                    uart_rxd;
    logic                                    uart_txd;
    logic [BYTES_PER_WORD*BITS_PER_BYTE-1:0] data_out_64;
    logic                                    data_out_done;

    modport slave (
        input  data_in_64, manual_start, uart_rxd,
        output uart_txd, data_out_64, data_out_done
    );

    modport master (
        output data_in_64, manual_start, uart_rxd,
        input  uart_txd, data_out_64, data_out_done
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx8.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx8
//  Description : 8N1 byte receiver. Two-flop synchronizer, start-bit glitch
//                rejection at half a bit, mid-bit sampling, one-cycle
//                byte-valid / framing-error strobes.
//  Options     : RX_FRAME_TIMEOUT_EN exposes the synchronized line level.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx8
    import uart_loopback64_pkg::*;
#(
    parameter int CLK_GOAL = 434
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rxd,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_framing_err
`ifdef RX_FRAME_TIMEOUT_EN
    ,
    output logic       o_rxd_sync
`endif
);

    localparam int            CW          = cnt_width(CLK_GOAL);
    localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLK_GOAL - 1);
    localparam logic [CW-1:0] c_HALF_LAST = CW'(CLK_GOAL / 2 - 1);

    logic            r_sync1, r_sync2, r_prev;
    rx_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_valid, r_ferr;
    logic            w_fall;

    assign w_fall        = r_prev & ~r_sync2;
    assign o_byte        = r_shift;
    assign o_byte_valid  = r_valid;
    assign o_framing_err = r_ferr;
`ifdef RX_FRAME_TIMEOUT_EN
    assign o_rxd_sync    = r_sync2;
`endif

    // Bring the asynchronous line into clk domain; keep one more stage for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Byte receive FSM: validate start at half-bit, then sample every full bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                    if (w_fall) r_state <= RX_START;
                end
                RX_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt   <= '0;
                        // Line back high at mid start bit means a glitch
                        r_state <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_bit == 3'(BITS_PER_BYTE - 1)) r_state <= RX_STOP;
                        else                                r_bit   <= r_bit + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_sync2) r_valid <= 1'b1;
                        else         r_ferr  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_loopback64.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loopback64
//  Description : 64-bit word over 8N1 UART. TX sends the latched word as
//                8 bytes (LSB byte first) back to back while armed; RX
//                rebuilds words and strobes data_out_done per full word.
//  Options     : RX_FRAME_TIMEOUT_EN - drop a partial word after the line
//                idles for more than TIMEOUT_MULT*CLK_GOAL cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_loopback64
    import uart_loopback64_pkg::*;
#(
    parameter int CLK_F    = 50_000_000,
    parameter int UART_BPS = 115200,
    parameter int CLK_GOAL = CLK_F / UART_BPS
)(
    input  logic              clk,
    input  logic              rst,
    uart_loopback64_if.slave  bus
);

    localparam int            CW         = cnt_width(CLK_GOAL);
    localparam logic [CW-1:0] c_BIT_LAST = CW'(CLK_GOAL - 1);

    // ---------------- transmit side ----------------
    logic          r_armed;
    tx_state_t     r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [2:0]    r_tx_byte;
    logic [63:0]   r_tx_shift;
    logic          r_txd;

    // ---------------- receive side -----------------
    logic [7:0]    w_rx_byte;
    logic          w_rx_valid;
    logic          w_rx_ferr;
    logic          w_timeout;
    logic [2:0]    r_idx;
    logic [63:0]   r_word;
    logic [63:0]   r_data_out;
    logic          r_done;

    assign bus.uart_txd      = r_txd;
    assign bus.data_out_64   = r_data_out;
    assign bus.data_out_done = r_done;

    // Arming is sticky: any manual_start sets it, only reset clears it
    always_ff @(posedge clk) begin
        if (rst)                   r_armed <= 1'b0;
        else if (bus.manual_start) r_armed <= 1'b1;
    end

    // TX FSM: shift register drains LSB-first, 10 bit times per byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_byte  <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_cnt <= '0;
                    if (r_armed) begin
                        r_tx_shift <= bus.data_in_64;
                        r_tx_byte  <= '0;
                        r_tx_bit   <= '0;
                        r_txd      <= 1'b0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_shift[0];
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_shift <= {1'b0, r_tx_shift[63:1]};
                        if (r_tx_bit == 3'(BITS_PER_BYTE - 1)) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                            r_txd    <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt <= '0;
                        r_tx_bit <= '0;
                        if (r_tx_byte != 3'(BYTES_PER_WORD - 1)) begin
                            r_tx_byte  <= r_tx_byte + 1'b1;
                            r_txd      <= 1'b0;
                            r_tx_state <= TX_START;
                        end else if (r_armed) begin
                            // Next frame starts with no idle gap, fresh word latched
                            r_tx_byte  <= '0;
                            r_tx_shift <= bus.data_in_64;
                            r_txd      <= 1'b0;
                            r_tx_state <= TX_START;
                        end else begin
                            r_txd      <= 1'b1;
                            r_tx_state <= TX_IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: begin
                    r_txd      <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

`ifdef RX_FRAME_TIMEOUT_EN
    localparam int            TW        = cnt_width(TIMEOUT_MULT * CLK_GOAL);
    localparam logic [TW-1:0] c_TIMEOUT = TW'(TIMEOUT_MULT * CLK_GOAL);

    logic          w_rxd_sync;
    logic [TW-1:0] r_idle_cnt;

    uart_rx8 #(.CLK_GOAL(CLK_GOAL)) u_rx (
        .clk           (clk),
        .rst           (rst),
        .i_rxd         (bus.uart_rxd),
        .o_byte        (w_rx_byte),
        .o_byte_valid  (w_rx_valid),
        .o_framing_err (w_rx_ferr),
        .o_rxd_sync    (w_rxd_sync)
    );

    // Count idle-high line time only while a partial word is pending
    always_ff @(posedge clk) begin
        if (rst || (r_idx == 3'd0) || !w_rxd_sync) r_idle_cnt <= '0;
        else if (r_idle_cnt != c_TIMEOUT)          r_idle_cnt <= r_idle_cnt + 1'b1;
    end

    assign w_timeout = (r_idle_cnt == c_TIMEOUT);
`else
    uart_rx8 #(.CLK_GOAL(CLK_GOAL)) u_rx (
        .clk           (clk),
        .rst           (rst),
        .i_rxd         (bus.uart_rxd),
        .o_byte        (w_rx_byte),
        .o_byte_valid  (w_rx_valid),
        .o_framing_err (w_rx_ferr)
    );

    assign w_timeout = 1'b0;
`endif

    // Word assembly: byte k lands in bits [8k+7:8k]; the 8th byte publishes the word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_word     <= '0;
            r_data_out <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_rx_ferr || w_timeout) begin
                r_idx <= '0;
            end else if (w_rx_valid) begin
                if (r_idx == 3'(BYTES_PER_WORD - 1)) begin
                    r_data_out <= {w_rx_byte, r_word[55:0]};
                    r_done     <= 1'b1;
                    r_idx      <= '0;
                end else begin
                    r_word[{r_idx, 3'b000} +: 8] <= w_rx_byte;
                    r_idx                        <= r_idx + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_loopback64.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_loopback64
//  Description : Self-checking bench for uart_loopback64: loopback words,
//                bit-level waveform, mid-frame reset, framing error and
//                start-glitch handling, partial-word persistence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_loopback64;

    localparam int G    = 16;              // clocks per bit used in this bench
    localparam int BPS  = 115200;
    localparam int FRM  = 80 * G;          // cycles per 64-bit frame
    localparam int N    = 8;               // loopback words

    typedef struct {
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;

    logic clk, rst;
    logic loop_en, tb_rxd;
    int   cyc;
    int   n_tests, n_fail;
    int   st_cyc[$];
    logic [63:0] st_dat[$];
    logic prev_done;
    vec_t tbl [N];

    uart_loopback64_if bus();

    assign bus.uart_rxd = loop_en ? bus.uart_txd : tb_rxd;

    uart_loopback64 #(.CLK_F(G * BPS), .UART_BPS(BPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish within 60000 cycles");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Strobe recorder; every strobe must be a single cycle wide
    always @(negedge clk) begin
        if (bus.data_out_done === 1'b1) begin
            st_cyc.push_back(cyc);
            st_dat.push_back(bus.data_out_64);
            chk("strobe_width_prev_cycle_low", {63'd0, prev_done}, 64'd0);
        end
        prev_done = bus.data_out_done;
    end

    // Serial line model: level of bit n (0..79) of an 8N1 frame carrying word w
    function automatic logic frame_bit(input logic [63:0] w, input int n);
        int b, p;
        b = n / 10;
        p = n % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return w[b*8 + p - 1];
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        tb_rxd = 1'b0;
        repeat (G) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            tb_rxd = b[k];
            repeat (G) @(negedge clk);
        end
        tb_rxd = stop;
        repeat (G) @(negedge clk);
        tb_rxd = 1'b1;
    endtask

    initial begin
        int t0, lim, snap, lows, lat;
        bit got;
        cyc = 0; n_tests = 0; n_fail = 0; prev_done = 1'b0;
        rst = 1'b1; loop_en = 1'b1; tb_rxd = 1'b1;
        bus.data_in_64 = '0; bus.manual_start = 1'b0;

        tbl[0] = '{64'h2d7e66091ed0a403, 64'h2d7e66091ed0a403};
        tbl[1] = '{64'hd253328dd2c0fc3c, 64'hd253328dd2c0fc3c};
        tbl[2] = '{64'h8162476652bdd1d0, 64'h8162476652bdd1d0};
        for (int i = 3; i < N; i++) begin
            tbl[i].din = {$urandom, $urandom};
            tbl[i].exp = tbl[i].din;       // loopback returns the word sent
        end

        // Reset state
        @(negedge clk);
        chk("reset_txd", {63'd0, bus.uart_txd}, 64'd1);
        chk("reset_data_out", bus.data_out_64, 64'd0);
        chk("reset_done", {63'd0, bus.data_out_done}, 64'd0);
        rst = 1'b0;

        // Arm with the first word
        bus.data_in_64   = tbl[0].din;
        bus.manual_start = 1'b1;
        repeat (2) @(negedge clk);
        bus.manual_start = 1'b0;
        lim = 0;
        while (bus.uart_txd !== 1'b0 && lim < 100) begin
            @(negedge clk);
            lim++;
        end
        chk("frame_start_seen", {63'd0, bus.uart_txd}, 64'd0);
        t0 = cyc;

        // First byte waveform: first and last cycle of each bit period
        for (int n = 0; n < 10; n++) begin
            wait_cyc(t0 + n*G);
            chk($sformatf("wave_bit%0d_first", n), {63'd0, bus.uart_txd},
                {63'd0, frame_bit(tbl[0].din, n)});
            wait_cyc(t0 + n*G + G - 1);
            chk($sformatf("wave_bit%0d_last", n), {63'd0, bus.uart_txd},
                {63'd0, frame_bit(tbl[0].din, n)});
        end
        wait_cyc(t0 + 10*G);
        bus.data_in_64 = tbl[1].din;       // mid-frame change

        // Table-driven loopback words
        for (int i = 0; i < N; i++) begin
            while (st_cyc.size() <= i && cyc < t0 + i*FRM + FRM + G) @(negedge clk);
            got = (st_cyc.size() > i);
            n_tests++;
            if (!got) begin
                n_fail++;
                $display("FAIL word%0d_strobe: no strobe by cycle %0d, want one", i, cyc);
                break;
            end
            chk($sformatf("word%0d_data", i), st_dat[i], tbl[i].exp);
            lat = st_cyc[i] - (t0 + i*FRM);
            n_tests++;
            if (lat < 79*G || lat > 80*G) begin
                n_fail++;
                $display("FAIL word%0d_latency: got %0d cycles, want %0d..%0d", i, lat, 79*G, 80*G);
            end
            if (i > 0)
                chk($sformatf("word%0d_spacing", i), 64'(st_cyc[i] - st_cyc[i-1]), 64'(FRM));
            if (i + 2 < N) begin
                wait_cyc(t0 + (i+1)*FRM + 10*G);
                bus.data_in_64 = tbl[i+2].din;
            end
        end

        // Reset during byte 3 of the next frame
        wait_cyc(t0 + N*FRM + 35*G);
        chk("strobes_before_reset", 64'(st_cyc.size()), 64'(N));
        rst = 1'b1;
        @(negedge clk);
        chk("txd_after_reset", {63'd0, bus.uart_txd}, 64'd1);
        rst = 1'b0;
        snap = st_cyc.size();
        lows = 0;
        repeat (3*FRM) begin
            @(negedge clk);
            if (bus.uart_txd !== 1'b1) lows++;
        end
        chk("txd_low_cycles_after_reset", 64'(lows), 64'd0);
        chk("strobes_after_reset", 64'(st_cyc.size()), 64'(snap));
        chk("data_out_after_reset", bus.data_out_64, 64'd0);

        // External line: glitch, 3 good bytes, framing error, then a full word
        loop_en = 1'b0;
        repeat (2*G) @(negedge clk);
        tb_rxd = 1'b0;
        repeat (G/4) @(negedge clk);
        tb_rxd = 1'b1;
        repeat (2*G) @(negedge clk);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        send_byte(8'hA3, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (G) @(negedge clk);
        for (int b = 1; b <= 8; b++) send_byte(8'(b), 1'b1);
        repeat (2*G) @(negedge clk);
        chk("framing_strobe_count", 64'(st_cyc.size()), 64'(snap + 1));
        chk("framing_word", bus.data_out_64, 64'h0807060504030201);

        // Long idle in the middle of a word
        snap = st_cyc.size();
        for (int b = 0; b < 4; b++) send_byte(8'h11 + 8'(b), 1'b1);
        repeat (25*G) @(negedge clk);
        for (int b = 4; b < 8; b++) send_byte(8'h11 + 8'(b), 1'b1);
        repeat (2*G) @(negedge clk);
`ifdef RX_FRAME_TIMEOUT_EN
        chk("idle_gap_strobe_count", 64'(st_cyc.size()), 64'(snap));
        chk("idle_gap_data_out", bus.data_out_64, 64'h0807060504030201);
`else
        chk("idle_gap_strobe_count", 64'(st_cyc.size()), 64'(snap + 1));
        chk("idle_gap_word", bus.data_out_64, 64'h1817161514131211);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
